// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: load sizes and default source indices.
package wb_pkg;
  localparam logic [1:0] LD_WORD = 2'b00;
  localparam logic [1:0] LD_BYTE = 2'b01;
  localparam logic [1:0] LD_HALF = 2'b10;

  localparam int SRC_ALU  = 0;
  localparam int SRC_MEM  = 1;
  localparam int SRC_LINK = 2;
endpackage

// File: rtl/wb_load_align.sv
// Combinational little-endian load lane select with zero/sign extension.
module wb_load_align
  import wb_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data,
  output logic        misalign
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = word[{addr_lo, 3'b000} +: 8];
  assign lane_h = word[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    data     = word;
    misalign = 1'b0;
    case (size)
      LD_BYTE: data = {{24{~is_unsigned & lane_b[7]}}, lane_b};
      LD_HALF: begin
        if (addr_lo[0]) begin
          data     = 32'd0;
          misalign = 1'b1;
        end else begin
          data = {{16{~is_unsigned & lane_h[15]}}, lane_h};
        end
      end
      default: data = word;
    endcase
  end

endmodule

// File: rtl/wb_select_stage.sv
// MEM/WB register with writeback source select, sticky error flag and retire counter.
// Load alignment/extension is built only when WB_LOAD_EXT_EN is defined.
module wb_select_stage
  import wb_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NSRC    = 3,
  parameter int SEL_W   = 2,
  parameter int MEM_SRC = SRC_MEM,
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   m_valid,
  input  logic                   m_wreg,
  input  logic [REG_AW-1:0]      m_rn,
  input  logic [SEL_W-1:0]       m_sel,
  input  logic [NSRC*DATA_W-1:0] m_src,
  input  logic [1:0]             m_ld_size,
  input  logic                   m_ld_unsigned,
  input  logic [1:0]             m_addr_lo,
  input  logic                   stall,
  input  logic                   flush,
  output logic                   w_valid,
  output logic                   w_we,
  output logic [REG_AW-1:0]      w_rn,
  output logic [DATA_W-1:0]      w_data,
  output logic                   err,
  output logic [CNT_W-1:0]       retire_cnt
);

  logic [DATA_W-1:0] sel_word;
  logic [DATA_W-1:0] ld_data;
  logic              sel_bad;
  logic              misalign;

  logic              vld_p0;
  logic              wreg_p0;
  logic [REG_AW-1:0] rn_p0;
  logic [DATA_W-1:0] data_p0;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;

  // Out-of-range selects fall through the loop and leave sel_word at zero.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (32'(m_sel) == i) sel_word = m_src[i*DATA_W +: DATA_W];
    end
  end

  assign sel_bad = (32'(m_sel) >= NSRC);

`ifdef WB_LOAD_EXT_EN
  logic [31:0] al_data;
  logic        al_mis;
  logic        is_mem;

  wb_load_align u_align (
    .word        (sel_word),
    .size        (m_ld_size),
    .is_unsigned (m_ld_unsigned),
    .addr_lo     (m_addr_lo),
    .data        (al_data),
    .misalign    (al_mis)
  );

  assign is_mem   = (32'(m_sel) == MEM_SRC);
  assign ld_data  = is_mem ? al_data : sel_word;
  assign misalign = is_mem & al_mis;
`else
  logic unused_ld;
  assign unused_ld = ^{m_ld_size, m_ld_unsigned, m_addr_lo};
  assign ld_data   = sel_word;
  assign misalign  = 1'b0;
`endif

  // Stage p0: MEM/WB register; a held write retires only on the cycle it leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      wreg_p0 <= 1'b0;
      rn_p0   <= '0;
      data_p0 <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (w_we && !stall) cnt_q <= cnt_q + CNT_W'(1);
      if (flush) begin
        vld_p0 <= 1'b0;
      end else if (!stall) begin
        vld_p0  <= m_valid;
        wreg_p0 <= m_wreg;
        rn_p0   <= m_rn;
        data_p0 <= ld_data;
        if (m_valid && (sel_bad || misalign)) err_q <= 1'b1;
      end
    end
  end

  assign w_valid    = vld_p0;
  assign w_rn       = rn_p0;
  assign w_data     = data_p0;
  assign w_we       = vld_p0 & wreg_p0 & (rn_p0 != '0);
  assign err        = err_q;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// Scoreboard bench for wb_select_stage; expectations follow WB_LOAD_EXT_EN when defined.
module tb_wb_select_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        m_valid, m_wreg;
  logic [4:0]  m_rn;
  logic [1:0]  m_sel;
  logic [95:0] m_src;
  logic [1:0]  m_ld_size;
  logic        m_ld_unsigned;
  logic [1:0]  m_addr_lo;
  logic        stall, flush;
  logic        w_valid, w_we, err;
  logic [4:0]  w_rn;
  logic [31:0] w_data, retire_cnt;

  typedef struct {
    logic        v;
    logic        we;
    logic [4:0]  rn;
    logic [31:0] data;
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic        mv = 0, mwr = 0, merr = 0;
  logic [4:0]  mrn = 0;
  logic [31:0] mdata = 0, mcnt = 0;

  wb_select_stage dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_wreg(m_wreg), .m_rn(m_rn),
    .m_sel(m_sel), .m_src(m_src), .m_ld_size(m_ld_size),
    .m_ld_unsigned(m_ld_unsigned), .m_addr_lo(m_addr_lo), .stall(stall),
    .flush(flush), .w_valid(w_valid), .w_we(w_we), .w_rn(w_rn),
    .w_data(w_data), .err(err), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] ref_data(input logic [1:0] sel, input logic [31:0] s0,
                                           input logic [31:0] s1, input logic [31:0] s2,
                                           input logic [1:0] sz, input logic uns,
                                           input logic [1:0] alo, output logic bad);
    logic [31:0] w;
    bad = 1'b0;
    case (sel)
      2'd0: w = s0;
      2'd1: w = s1;
      2'd2: w = s2;
      default: begin bad = 1'b1; return 32'd0; end
    endcase
`ifdef WB_LOAD_EXT_EN
    if (sel == 2'd1) begin
      if (sz == 2'b01) begin
        w = (w >> (alo * 8)) & 32'hFF;
        if (!uns && w[7]) w = w | 32'hFFFF_FF00;
      end else if (sz == 2'b10) begin
        if (alo[0]) begin bad = 1'b1; return 32'd0; end
        w = (w >> (alo[1] * 16)) & 32'hFFFF;
        if (!uns && w[15]) w = w | 32'hFFFF_0000;
      end
    end
`endif
    return w;
  endfunction

  task automatic step(input logic r, input logic v, input logic wr, input logic [4:0] rn,
                      input logic [1:0] sel, input logic [31:0] s0, input logic [31:0] s1,
                      input logic [31:0] s2, input logic [1:0] sz, input logic uns,
                      input logic [1:0] alo, input logic st, input logic fl);
    exp_t e, got;
    logic bad;
    logic [31:0] d;
    rst = r; m_valid = v; m_wreg = wr; m_rn = rn; m_sel = sel;
    m_src = {s2, s1, s0}; m_ld_size = sz; m_ld_unsigned = uns; m_addr_lo = alo;
    stall = st; flush = fl;
    d = ref_data(sel, s0, s1, s2, sz, uns, alo, bad);
    if (r) begin
      mv = 0; mwr = 0; mrn = 0; mdata = 0; merr = 0; mcnt = 0;
    end else begin
      if (mv && mwr && (mrn != 0) && !st) mcnt = mcnt + 1;
      if (fl) mv = 0;
      else if (!st) begin
        mv = v; mwr = wr; mrn = rn; mdata = d;
        if (v && bad) merr = 1;
      end
    end
    e.v = mv; e.we = mv & mwr & (mrn != 0); e.rn = mrn; e.data = mdata;
    e.err = merr; e.cnt = mcnt;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      check("queue_empty", 32'd0, 32'd1);
    end else begin
      got = q.pop_front();
      check("w_valid", {31'd0, w_valid}, {31'd0, got.v});
      check("w_we", {31'd0, w_we}, {31'd0, got.we});
      check("w_rn", {27'd0, w_rn}, {27'd0, got.rn});
      check("w_data", w_data, got.data);
      check("err", {31'd0, err}, {31'd0, got.err});
      check("retire_cnt", retire_cnt, got.cnt);
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; m_valid = 0; m_wreg = 0; m_rn = 0; m_sel = 0; m_src = '0;
    m_ld_size = 0; m_ld_unsigned = 0; m_addr_lo = 0; stall = 0; flush = 0;
    @(posedge clk); #1;

    // Reset with random inputs
    for (int i = 0; i < 2; i++)
      step(1, 1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom), $urandom, $urandom,
           $urandom, 2'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
    check("rst_we", {31'd0, w_we}, 32'd0);
    check("rst_cnt", retire_cnt, 32'd0);

    // ALU writeback
    step(0, 1, 1, 5, 0, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0);
    check("alu_data", w_data, 32'h1234_5678);
    check("alu_we", {31'd0, w_we}, 32'd1);
    idle();
    check("alu_cnt", retire_cnt, 32'd1);

    // Loads through the memory source
    step(0, 1, 1, 6, 1, 0, 32'h8899_AABB, 0, 2'b01, 0, 2, 0, 0);
`ifdef WB_LOAD_EXT_EN
    check("lb_signed", w_data, 32'hFFFF_FF99);
`else
    check("lb_passthru", w_data, 32'h8899_AABB);
`endif
    step(0, 1, 1, 6, 1, 0, 32'h8899_AABB, 0, 2'b01, 1, 2, 0, 0);
    step(0, 1, 1, 6, 1, 0, 32'h8899_AABB, 0, 2'b10, 0, 2, 0, 0);
    step(0, 1, 1, 6, 1, 0, 32'h8899_AABB, 0, 2'b10, 1, 0, 0, 0);
    step(0, 1, 1, 6, 1, 0, 32'h8899_AABB, 0, 2'b01, 0, 3, 0, 0);
    step(0, 1, 1, 6, 1, 0, 32'h8899_AABB, 0, 2'b11, 0, 1, 0, 0);

    // Misaligned half, then err must stay until reset
    step(0, 1, 1, 7, 1, 0, 32'h8899_AABB, 0, 2'b10, 0, 1, 0, 0);
`ifdef WB_LOAD_EXT_EN
    check("mis_err", {31'd0, err}, 32'd1);
`else
    check("mis_err", {31'd0, err}, 32'd0);
`endif
    idle(); idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // r0 write and out-of-range select
    step(0, 1, 1, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0);
    check("r0_we", {31'd0, w_we}, 32'd0);
    idle();
    step(0, 1, 1, 3, 3, 32'h1, 32'h2, 32'h3, 0, 0, 0, 0, 0);
    check("sel3_data", w_data, 32'd0);
    check("sel3_err", {31'd0, err}, 32'd1);
    step(0, 0, 1, 3, 3, 32'h1, 32'h2, 32'h3, 0, 0, 0, 0, 0);
    step(0, 1, 1, 4, 2, 32'h1, 32'h2, 32'hA5A5_0008, 0, 0, 0, 0, 0);

    // Stall a valid write for three cycles, then release
    step(0, 1, 1, 9, 0, 32'hCAFE_0009, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      step(0, 1, 1, 10, 0, 32'h0BAD_0000 + i, 0, 0, 0, 0, 0, 1, 0);
    check("stall_hold", w_data, 32'hCAFE_0009);
    step(0, 1, 1, 11, 0, 32'h0000_0011, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 12, 0, 32'h0000_0012, 0, 0, 0, 0, 0, 1, 1);
    check("flush_stall", {31'd0, w_valid}, 32'd0);
    idle();

    // Random traffic
    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom), 5'($urandom),
           2'($urandom), $urandom, $urandom, $urandom, 2'($urandom), 1'($urandom),
           2'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
